branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Set-associative branch target buffer (1 or 2 ways) with saturating direction
// counters, zero-latency lookup, per-set LRU and a saturating mispredict counter.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int WAYS    = 2,
  parameter int ADDR_W  = 30,
  parameter int CTR_W   = 2,
  parameter int MCNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic [ADDR_W-1:0] cpc,
  output logic              phit,
  output logic [ADDR_W-1:0] addr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              flush,
  output logic [MCNT_W-1:0] mispred_cnt
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'(1) << (CTR_W - 1);
  localparam logic [MCNT_W-1:0] MCNT_MAX = {MCNT_W{1'b1}};

  logic              valid_r [WAYS][SETS];
  logic [TAG_W-1:0]  tag_r   [WAYS][SETS];
  logic [ADDR_W-1:0] tgt_r   [WAYS][SETS];
  logic [CTR_W-1:0]  ctr_r   [WAYS][SETS];
  // lru_r holds the index of the least-recently-used way of each set
  logic              lru_r   [SETS];

  logic [IDX_W-1:0]  look_set_s;
  logic [TAG_W-1:0]  look_tag_s;
  logic              look_hit_s;
  logic [ADDR_W-1:0] look_tgt_s;
  logic [CTR_W-1:0]  look_ctr_s;

  logic [IDX_W-1:0]  upd_set_s;
  logic [TAG_W-1:0]  upd_tag_s;
  logic              upd_hit_s;
  logic              upd_hit_way_s;
  logic              victim_s;
  logic              wr_en_s;
  logic              wr_way_s;
  logic [ADDR_W-1:0] wr_tgt_s;
  logic [CTR_W-1:0]  wr_ctr_s;
  logic [CTR_W-1:0]  old_ctr_s;
  logic [ADDR_W-1:0] old_tgt_s;

  assign look_set_s = cpc[IDX_W-1:0];
  assign look_tag_s = cpc[ADDR_W-1:IDX_W];
  assign upd_set_s  = upd_pc[IDX_W-1:0];
  assign upd_tag_s  = upd_pc[ADDR_W-1:IDX_W];

  // Lookup: first matching way from way0 upward wins
  always_comb begin
    look_hit_s = 1'b0;
    look_tgt_s = '0;
    look_ctr_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!look_hit_s && valid_r[w][look_set_s] && (tag_r[w][look_set_s] == look_tag_s)) begin
        look_hit_s = 1'b1;
        look_tgt_s = tgt_r[w][look_set_s];
        look_ctr_s = ctr_r[w][look_set_s];
      end else begin
        look_hit_s = look_hit_s;
      end
    end
  end

  // Prediction outputs: target on a strong-enough hit, else sequential next word
  always_comb begin
    phit = look_hit_s & look_ctr_s[CTR_W-1];
    if (phit) begin
      addr = look_tgt_s;
    end else begin
      addr = cpc + ADDR_W'(1);
    end
  end

  // Update decode: hit way, victim way and the new entry contents
  always_comb begin
    upd_hit_s     = 1'b0;
    upd_hit_way_s = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!upd_hit_s && valid_r[w][upd_set_s] && (tag_r[w][upd_set_s] == upd_tag_s)) begin
        upd_hit_s     = 1'b1;
        upd_hit_way_s = w[0];
      end else begin
        upd_hit_s = upd_hit_s;
      end
    end

    victim_s = (WAYS > 1) ? lru_r[upd_set_s] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_r[w][upd_set_s]) begin
        victim_s = w[0];
      end else begin
        victim_s = victim_s;
      end
    end

    wr_way_s  = upd_hit_s ? upd_hit_way_s : victim_s;
    old_ctr_s = ctr_r[wr_way_s][upd_set_s];
    old_tgt_s = tgt_r[wr_way_s][upd_set_s];
    wr_en_s   = upd_valid & en & ~flush & (upd_hit_s | upd_taken);

    if (!upd_hit_s) begin
      wr_ctr_s = CTR_INIT;
      wr_tgt_s = upd_target;
    end else if (upd_taken) begin
      wr_ctr_s = (old_ctr_s == CTR_MAX) ? old_ctr_s : old_ctr_s + CTR_W'(1);
      wr_tgt_s = upd_target;
    end else begin
      wr_ctr_s = (old_ctr_s == '0) ? old_ctr_s : old_ctr_s - CTR_W'(1);
      wr_tgt_s = old_tgt_s;
    end
  end

  // Table state: async reset, flush beats any simultaneous update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        lru_r[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_r[w][s] <= 1'b0;
          tag_r[w][s]   <= '0;
          tgt_r[w][s]   <= '0;
          ctr_r[w][s]   <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        lru_r[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_r[w][s] <= 1'b0;
        end
      end
    end else if (wr_en_s) begin
      valid_r[wr_way_s][upd_set_s] <= 1'b1;
      tag_r[wr_way_s][upd_set_s]   <= upd_tag_s;
      tgt_r[wr_way_s][upd_set_s]   <= wr_tgt_s;
      ctr_r[wr_way_s][upd_set_s]   <= wr_ctr_s;
      lru_r[upd_set_s]             <= ~wr_way_s;
    end
  end

  // Mispredict counter counts even updates that a flush drops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mispred_cnt <= '0;
    end else if (upd_valid && en && upd_mispred && (mispred_cnt != MCNT_MAX)) begin
      mispred_cnt <= mispred_cnt + MCNT_W'(1);
    end
  end

endmodule
